backoff_timer: RTL
==================

// Module: backoff_timer
// PURPOSE
//  Truncated binary exponential backoff timer for the half-duplex MAC transmit path.
//  Sits directly downstream of the 32-bit xorshift generator and consumes its rand word on each collision.
//  Counts a random number of slot times, then tells the TX FSM it may retry.
//  Gives up after ATTEMPT_LIMIT collisions.
// PARAMETERS
//  SLOT_CYCLES    128  clk cycles per slot time (512 bit times, MII nibble @25MHz)
//  BACKOFF_LIMIT  10   cap on exponent k; slot range is 0..2^k-1
//  ATTEMPT_LIMIT  16   collision count that triggers excess_col abort
// PORTS
//  clk            in   1   clock
//  arst_n         in   1   reset; asynchronous, active-low
//  rand           in   32  random word from the xorshift generator; sampled on the collision edge
//  collision      in   1   1-cycle pulse from TX FSM: collision on current attempt
//  tx_success     in   1   1-cycle pulse: frame sent OK; clears attempt count
//  cancel         in   1   abort a running backoff; no done pulse
//  backoff_busy   out  1   high while counting slots (state WAIT)
//  backoff_done   out  1   1-cycle pulse: retry permitted
//  excess_col     out  1   1-cycle pulse: ATTEMPT_LIMIT reached, frame dropped
//  attempt        out  5   collisions on the current frame (0..ATTEMPT_LIMIT-1)
// BEHAVIOUR
//  - Reset: state IDLE; backoff_busy=0, backoff_done=0, excess_col=0, attempt=0.
//    Slot and cycle counters = 0. Reset mid-WAIT aborts with no done pulse.
//  - FSM states: IDLE, WAIT. backoff_done and excess_col are registered pulses.
//  - IDLE, collision at edge T0:
//    - n = attempt+1.
//    - If n==ATTEMPT_LIMIT: excess_col=1 for cycle T0+1; attempt<=0; stay IDLE.
//    - Otherwise: attempt<=n; k=min(n,BACKOFF_LIMIT); r=rand & ((1<<k)-1), a k-bit mask on rand[9:0].
//      - r==0: backoff_done=1 for cycle T0+1; stay IDLE.
//      - r>0: slots<=r; cyc<=0; go WAIT.
//  - WAIT:
//    - cyc counts 0..SLOT_CYCLES-1; on wrap, slots decrements.
//    - On the final cycle of the last slot: go IDLE and pulse backoff_done.
//    - General latency: backoff_done is high during cycle T0+1+r*SLOT_CYCLES.
//    - backoff_busy is high from T0+1 through the cycle before done.
//  - collision while WAIT: ignored; protocol violation by the TX FSM; counted only if stats are enabled.
//  - tx_success: attempt<=0 in any state; a running WAIT continues.
//    - tx_success and collision in the same IDLE cycle: tx_success applied first.
//      The collision is then treated as n=1.
//  - cancel in WAIT: go IDLE next edge; no backoff_done; attempt kept.
//    - cancel in IDLE: no effect.
//    - cancel and the final WAIT cycle together: cancel wins, no done.
//  - Widths: slots is BACKOFF_LIMIT bits; cyc is $clog2(SLOT_CYCLES) bits.
//    attempt saturates below ATTEMPT_LIMIT by construction.
// CONFIGURATION
//  BACKOFF_STATS_EN defined:
//    - Adds outputs col_total[15:0] and excess_total[15:0]. Both are saturating at 16'hFFFF and reset to 0.
//    - col_total increments on every collision pulse, including those ignored in WAIT.
//    - excess_total increments on every excess_col pulse.
//  BACKOFF_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Assert arst_n=0 mid-WAIT -> all outputs 0 immediately; after release, attempt=0, no done pulse.
//  2. rand=32'hFFFF_FFFF, first collision at T0 -> attempt=1, r=1, busy for 128 cycles, done at T0+129.
//  3. rand=32'h0000_0000, collision -> done at T0+1, busy never high.
//  4. rand=32'hFFFF_FFFF, collisions 10 and 11 (SLOT_CYCLES=4 for sim) -> r=1023 both times.
//     Done at T0+1+4092 for each.
//  5. 16 back-to-back collisions, each after its done -> 16th gives excess_col at T0+1, attempt=0, no done.
//  6. cancel 50 cycles into a 3-slot wait -> busy drops next cycle, no done, attempt unchanged.
//     With BACKOFF_STATS_EN, col_total counts the collision.

Source files
------------

// File: rtl/backoff_timer.sv
// Truncated binary exponential backoff timer for the half-duplex MAC transmit path.
// Define BACKOFF_STATS_EN to add saturating col_total / excess_total counters.
module backoff_timer #(
    parameter int unsigned SLOT_CYCLES   = 128,
    parameter int unsigned BACKOFF_LIMIT = 10,
    parameter int unsigned ATTEMPT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [31:0] rand_word,   // xorshift output; "rand" is a reserved word
    input  logic        collision,
    input  logic        tx_success,
    input  logic        cancel,
    output logic        backoff_busy,
    output logic        backoff_done,
    output logic        excess_col,
    output logic [4:0]  attempt
`ifdef BACKOFF_STATS_EN
    ,
    output logic [15:0] col_total,
    output logic [15:0] excess_total
`endif
);
    localparam int unsigned CycW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CycW-1:0] CycLast = CycW'(SLOT_CYCLES - 1);
    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [BACKOFF_LIMIT-1:0] slots_q, slots_d;
    logic [CycW-1:0]          cyc_q, cyc_d;
    logic [4:0]               attempt_q, attempt_d;
    logic                     done_q, done_d;
    logic                     excess_q, excess_d;

    logic [4:0]               attempt_base;
    logic [5:0]               n;
    logic [BACKOFF_LIMIT-1:0] mask;
    logic [BACKOFF_LIMIT-1:0] r;
    logic                     last_cycle;
    logic                     unused_rand;

    assign unused_rand = ^rand_word[31:BACKOFF_LIMIT];

    // A same-cycle tx_success clears the count before the collision is applied.
    assign attempt_base = tx_success ? 5'd0 : attempt_q;
    assign n            = {1'b0, attempt_base} + 6'd1;

    // Bit i is kept when i < min(n, BACKOFF_LIMIT); i never reaches the limit here.
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(BACKOFF_LIMIT); i++) begin
            mask[i] = (i < int'(n));
        end
    end

    assign r          = rand_word[BACKOFF_LIMIT-1:0] & mask;
    assign last_cycle = (slots_q == BACKOFF_LIMIT'(1)) && (cyc_q == CycLast);

    always_comb begin
        state_d   = state_q;
        slots_d   = slots_q;
        cyc_d     = cyc_q;
        attempt_d = attempt_base;
        done_d    = 1'b0;
        excess_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (collision) begin
                    if (n == 6'(ATTEMPT_LIMIT)) begin
                        excess_d  = 1'b1;
                        attempt_d = 5'd0;
                    end else begin
                        attempt_d = n[4:0];
                        if (r == '0) begin
                            done_d = 1'b1;
                        end else begin
                            slots_d = r;
                            cyc_d   = '0;
                            state_d = StWait;
                        end
                    end
                end
            end
            StWait: begin
                if (cancel) begin
                    state_d = StIdle;
                end else if (last_cycle) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (cyc_q == CycLast) begin
                    cyc_d   = '0;
                    slots_d = slots_q - BACKOFF_LIMIT'(1);
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= StIdle;
            slots_q   <= '0;
            cyc_q     <= '0;
            attempt_q <= '0;
            done_q    <= 1'b0;
            excess_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            slots_q   <= slots_d;
            cyc_q     <= cyc_d;
            attempt_q <= attempt_d;
            done_q    <= done_d;
            excess_q  <= excess_d;
        end
    end

    assign backoff_busy = (state_q == StWait);
    assign backoff_done = done_q;
    assign excess_col   = excess_q;
    assign attempt      = attempt_q;

`ifdef BACKOFF_STATS_EN
    logic [15:0] col_total_q, col_total_d;
    logic [15:0] excess_total_q, excess_total_d;

    // Collisions seen in WAIT are counted even though the FSM ignores them.
    always_comb begin
        col_total_d    = col_total_q;
        excess_total_d = excess_total_q;
        if (collision && col_total_q != 16'hFFFF) begin
            col_total_d = col_total_q + 16'd1;
        end
        if (excess_d && excess_total_q != 16'hFFFF) begin
            excess_total_d = excess_total_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            col_total_q    <= '0;
            excess_total_q <= '0;
        end else begin
            col_total_q    <= col_total_d;
            excess_total_q <= excess_total_d;
        end
    end

    assign col_total    = col_total_q;
    assign excess_total = excess_total_q;
`endif
endmodule
